// File: rtl/genesis_loader_pkg.sv
// Shared types and constants for the Genesis ROM loader.
package genesis_loader_pkg;
  typedef enum logic [1:0] {IDLE, RDBUF, EMIT0, EMIT1} ld_state_e;
  localparam int SMD_HDR = 512;
  localparam int SMD_BLK = 16384;
endpackage

// File: rtl/smd_half_buf.sv
// Simple dual-port RAM holding the odd-byte half of one SMD block.
module smd_half_buf #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [15:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [15:0]       rdata_o
);
  logic [15:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/smd_rom_loader.sv
// ioctl download -> ddram write bridge: byte-swap (plain) or SMD de-interleave,
// with toggle handshake to ddram and ioctl_wait back-pressure.
module smd_rom_loader
  import genesis_loader_pkg::*;
#(
  parameter int AW        = 25,
  parameter int HDR_BYTES = SMD_HDR,
  parameter int BLK_BYTES = SMD_BLK
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [15:0]   ioctl_data,
  input  logic          smd_mode,
  output logic          ioctl_wait,
  output logic [AW-1:0] rom_waddr,
  output logic [15:0]   rom_din,
  output logic          rom_wr,
  input  logic          rom_wrack,
  output logic [AW-1:0] rom_size,
  output logic          protocol_err
);
  localparam int BLK_LG = $clog2(BLK_BYTES);
  localparam int KW     = BLK_LG - 2;

  ld_state_e     state_q, state_d;
  logic          dl_q, smd_q, smd_d, pair_q, pair_d;
  logic          wait_q, wait_d, wr_q, wr_d, perr_q, perr_d;
  logic [AW-1:0] waddr_q, waddr_d, size_q, size_d, size_base, size_cand;
  logic [15:0]   din_q, din_d, data_q, data_d;
  logic [7:0]    bhi_q, bhi_d;
  logic          buf_we, buf_re;
  logic [15:0]   buf_rdata;

  // Word offset past the header; bit 0 of the byte address never matters in SMD mode.
  logic [AW-2:0] offw;
  logic          dl_rise, smd_now, accept, in_hdr, half, pending;
  logic [KW-1:0] k;

  assign offw     = ioctl_addr[AW-1:1] - (AW-1)'(HDR_BYTES / 2);
  assign half     = offw[BLK_LG-2];
  assign k        = offw[KW-1:0];
  assign in_hdr   = ioctl_addr < AW'(HDR_BYTES);
  assign dl_rise  = ioctl_download & ~dl_q;
  assign smd_now  = dl_rise ? smd_mode : smd_q;
  assign accept   = ioctl_wr & ~wait_q & (state_q == IDLE);
  assign pending  = wr_q != rom_wrack;
  assign size_base = dl_rise ? '0 : size_q;
  assign size_cand = waddr_q + AW'(2);

  smd_half_buf #(.ADDR_W(KW)) u_buf (
    .clk_i   (clk_sys),
    .we_i    (buf_we),
    .waddr_i (k),
    .wdata_i (ioctl_data),
    .re_i    (buf_re),
    .raddr_i (k),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d = state_q;
    smd_d   = smd_now;
    pair_d  = pair_q;
    wait_d  = wait_q;
    wr_d    = wr_q;
    perr_d  = dl_rise ? 1'b0 : perr_q;
    waddr_d = waddr_q;
    din_d   = din_q;
    data_d  = data_q;
    bhi_d   = bhi_q;
    size_d  = size_base;
    buf_we  = 1'b0;
    buf_re  = 1'b0;
    if (ioctl_wr && !accept) perr_d = 1'b1;
    unique case (state_q)
      IDLE: if (accept) begin
        if (!smd_now) begin
          waddr_d = ioctl_addr;
          din_d   = {ioctl_data[7:0], ioctl_data[15:8]};
          wr_d    = ~wr_q;
          wait_d  = 1'b1;
          pair_d  = 1'b0;
          state_d = EMIT0;
        end else if (!in_hdr) begin
          if (!half) begin
            buf_we = 1'b1;
          end else begin
            buf_re  = 1'b1;
            wait_d  = 1'b1;
            pair_d  = 1'b1;
            data_d  = ioctl_data;
            waddr_d = {offw[AW-2:BLK_LG-1], k, 2'b00};
            state_d = RDBUF;
          end
        end
      end
      RDBUF: begin
        din_d   = {data_q[7:0], buf_rdata[7:0]};
        bhi_d   = buf_rdata[15:8];
        wr_d    = ~wr_q;
        state_d = EMIT0;
      end
      EMIT0: if (!pending) begin
        size_d = (size_cand > size_base) ? size_cand : size_base;
        if (pair_q) begin
          waddr_d = {waddr_q[AW-1:2], 2'b10};
          din_d   = {data_q[15:8], bhi_q};
          wr_d    = ~wr_q;
          state_d = EMIT1;
        end else begin
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
      EMIT1: if (!pending) begin
        size_d  = (size_cand > size_base) ? size_cand : size_base;
        wait_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
      smd_q   <= 1'b0;
      pair_q  <= 1'b0;
      wait_q  <= 1'b0;
      wr_q    <= rom_wrack;  // abandon any in-flight request
      perr_q  <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
      data_q  <= '0;
      bhi_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      smd_q   <= smd_d;
      pair_q  <= pair_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      data_q  <= data_d;
      bhi_q   <= bhi_d;
      size_q  <= size_d;
    end
  end

  assign ioctl_wait   = wait_q;
  assign rom_waddr    = waddr_q;
  assign rom_din      = din_q;
  assign rom_wr       = wr_q;
  assign rom_size     = size_q;
  assign protocol_err = perr_q;
endmodule
